// File: rtl/axi4_reg_responder.sv
// Single-beat AXI4 subordinate exposing NREGS 32-bit control/status registers.
// Optional byte-strobe writes are enabled by defining AXI_REG_WSTRB_EN.
module axi4_reg_responder #(
    parameter int unsigned        ALEN      = 32,
    parameter int unsigned        XLEN      = 32,
    parameter int unsigned        IDLEN     = 5,
    parameter int unsigned        NREGS     = 8,
    parameter logic [ALEN-1:0]    BASE_ADDR = 32'h0001_0000,
    parameter logic [NREGS-1:0]   RO_MASK   = 8'h00
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ALEN-1:0]         aw_addr,
    input  logic [IDLEN-1:0]        aw_id,
    input  logic                    aw_valid,
    output logic                    aw_ready,
    input  logic [XLEN-1:0]         w_data,
    input  logic [XLEN/8-1:0]       w_strb,
    input  logic                    w_valid,
    output logic                    w_ready,
    output logic [IDLEN-1:0]        b_id,
    output logic [1:0]              b_resp,
    output logic                    b_valid,
    input  logic                    b_ready,
    input  logic [ALEN-1:0]         ar_addr,
    input  logic [IDLEN-1:0]        ar_id,
    input  logic                    ar_valid,
    output logic                    ar_ready,
    output logic [XLEN-1:0]         r_data,
    output logic [IDLEN-1:0]        r_id,
    output logic [1:0]              r_resp,
    output logic                    r_last,
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [NREGS*XLEN-1:0]   ctrl_o,
    input  logic [NREGS*XLEN-1:0]   status_i,
    output logic [NREGS-1:0]        wr_pulse_o
);

    localparam logic [2:0] W_IDLE   = 3'd0;
    localparam logic [2:0] W_DATA   = 3'd1;
    localparam logic [2:0] W_ADDR   = 3'd2;
    localparam logic [2:0] W_COMMIT = 3'd3;
    localparam logic [2:0] W_RESP   = 3'd4;

    localparam logic [0:0] R_IDLE   = 1'b0;
    localparam logic [0:0] R_RESP   = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic addr_hit(input logic [ALEN-1:0] addr);
        logic [ALEN-1:0] word;
        word = (addr - BASE_ADDR) >> 2'd2;
        return (addr >= BASE_ADDR) && (word < ALEN'(NREGS));
    endfunction

    function automatic logic [3:0] addr_idx(input logic [ALEN-1:0] addr);
        logic [ALEN-1:0] word;
        word = (addr - BASE_ADDR) >> 2'd2;
        return word[3:0];
    endfunction

`ifdef AXI_REG_WSTRB_EN
    function automatic logic [XLEN-1:0] merge_bytes(input logic [XLEN-1:0] old_v,
                                                    input logic [XLEN-1:0] new_v,
                                                    input logic [XLEN/8-1:0] strb);
        logic [XLEN-1:0] res;
        res = old_v;
        for (int b = 0; b < XLEN/8; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_v[b*8 +: 8];
            end
        end
        return res;
    endfunction
`endif

    logic [2:0]             w_state_r;
    logic [2:0]             w_state_nx_s;
    logic [0:0]             r_state_r;
    logic [0:0]             r_state_nx_s;
    logic                   aw_ready_r;
    logic                   w_ready_r;
    logic                   ar_ready_r;
    logic                   aw_hs_s;
    logic                   w_hs_s;
    logic                   ar_hs_s;
    logic                   b_hs_s;
    logic                   r_hs_s;
    logic [ALEN-1:0]        aw_addr_r;
    logic [IDLEN-1:0]       aw_id_r;
    logic [XLEN-1:0]        w_data_r;
`ifdef AXI_REG_WSTRB_EN
    logic [XLEN/8-1:0]      w_strb_r;
`else
    logic                   unused_strb_s;
`endif
    logic [NREGS*XLEN-1:0]  ctrl_r;
    logic [NREGS-1:0]       wr_pulse_r;
    logic                   b_valid_r;
    logic [IDLEN-1:0]       b_id_r;
    logic [1:0]             b_resp_r;
    logic                   r_valid_r;
    logic [IDLEN-1:0]       r_id_r;
    logic [1:0]             r_resp_r;
    logic [XLEN-1:0]        r_data_r;
    logic                   wr_hit_s;
    logic [3:0]             wr_idx_s;
    logic                   wr_ro_s;
    logic                   rd_hit_s;
    logic [3:0]             rd_idx_s;
    logic [XLEN-1:0]        rd_data_s;

`ifndef AXI_REG_WSTRB_EN
    assign unused_strb_s = ^w_strb;
`endif

    assign aw_hs_s = aw_valid & aw_ready_r;
    assign w_hs_s  = w_valid & w_ready_r;
    assign ar_hs_s = ar_valid & ar_ready_r;
    assign b_hs_s  = b_valid_r & b_ready;
    assign r_hs_s  = r_valid_r & r_ready;

    assign aw_ready   = aw_ready_r;
    assign w_ready    = w_ready_r;
    assign ar_ready   = ar_ready_r;
    assign b_valid    = b_valid_r;
    assign b_id       = b_id_r;
    assign b_resp     = b_resp_r;
    assign r_valid    = r_valid_r;
    assign r_id       = r_id_r;
    assign r_resp     = r_resp_r;
    assign r_data     = r_data_r;
    assign r_last     = 1'b1;
    assign ctrl_o     = ctrl_r;
    assign wr_pulse_o = wr_pulse_r;

    // Write-channel next state: AW and W may arrive together or in either order
    always_comb begin
        w_state_nx_s = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    w_state_nx_s = W_COMMIT;
                end else if (aw_hs_s) begin
                    w_state_nx_s = W_DATA;
                end else if (w_hs_s) begin
                    w_state_nx_s = W_ADDR;
                end else begin
                    w_state_nx_s = W_IDLE;
                end
            end
            W_DATA:   w_state_nx_s = w_hs_s ? W_COMMIT : W_DATA;
            W_ADDR:   w_state_nx_s = aw_hs_s ? W_COMMIT : W_ADDR;
            W_COMMIT: w_state_nx_s = W_RESP;
            W_RESP:   w_state_nx_s = b_hs_s ? W_IDLE : W_RESP;
            default:  w_state_nx_s = W_IDLE;
        endcase
    end

    // Read-channel next state
    always_comb begin
        r_state_nx_s = r_state_r;
        case (r_state_r)
            R_IDLE:  r_state_nx_s = ar_hs_s ? R_RESP : R_IDLE;
            R_RESP:  r_state_nx_s = r_hs_s ? R_IDLE : R_RESP;
            default: r_state_nx_s = R_IDLE;
        endcase
    end

    // Address decode for the captured write and the incoming read
    always_comb begin
        wr_hit_s  = addr_hit(aw_addr_r);
        wr_idx_s  = addr_idx(aw_addr_r);
        rd_hit_s  = addr_hit(ar_addr);
        rd_idx_s  = addr_idx(ar_addr);
        wr_ro_s   = 1'b0;
        rd_data_s = {XLEN{1'b0}};
        for (int i = 0; i < NREGS; i++) begin
            wr_ro_s = wr_ro_s | (RO_MASK[i] & (wr_idx_s == i[3:0]));
            if (rd_hit_s && (rd_idx_s == i[3:0])) begin
                rd_data_s = RO_MASK[i] ? status_i[i*XLEN +: XLEN] : ctrl_r[i*XLEN +: XLEN];
            end else begin
                rd_data_s = rd_data_s;
            end
        end
    end

    // Write path: capture requests, commit the register, hold the B response
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_r  <= W_IDLE;
            aw_ready_r <= 1'b1;
            w_ready_r  <= 1'b1;
            aw_addr_r  <= {ALEN{1'b0}};
            aw_id_r    <= {IDLEN{1'b0}};
            w_data_r   <= {XLEN{1'b0}};
`ifdef AXI_REG_WSTRB_EN
            w_strb_r   <= {(XLEN/8){1'b0}};
`endif
            ctrl_r     <= {(NREGS*XLEN){1'b0}};
            wr_pulse_r <= {NREGS{1'b0}};
            b_valid_r  <= 1'b0;
            b_id_r     <= {IDLEN{1'b0}};
            b_resp_r   <= RESP_OKAY;
        end else begin
            w_state_r  <= w_state_nx_s;
            aw_ready_r <= (w_state_nx_s == W_IDLE) || (w_state_nx_s == W_ADDR);
            w_ready_r  <= (w_state_nx_s == W_IDLE) || (w_state_nx_s == W_DATA);
            wr_pulse_r <= {NREGS{1'b0}};
            if (aw_hs_s) begin
                aw_addr_r <= aw_addr;
                aw_id_r   <= aw_id;
            end
            if (w_hs_s) begin
                w_data_r <= w_data;
`ifdef AXI_REG_WSTRB_EN
                w_strb_r <= w_strb;
`endif
            end
            if (w_state_r == W_COMMIT) begin
                b_valid_r <= 1'b1;
                b_id_r    <= aw_id_r;
                b_resp_r  <= (wr_hit_s && !wr_ro_s) ? RESP_OKAY : RESP_SLVERR;
                for (int i = 0; i < NREGS; i++) begin
                    if (wr_hit_s && !RO_MASK[i] && (wr_idx_s == i[3:0])) begin
`ifdef AXI_REG_WSTRB_EN
                        ctrl_r[i*XLEN +: XLEN] <= merge_bytes(ctrl_r[i*XLEN +: XLEN], w_data_r, w_strb_r);
`else
                        ctrl_r[i*XLEN +: XLEN] <= w_data_r;
`endif
                        wr_pulse_r[i] <= 1'b1;
                    end
                end
            end else if (b_hs_s) begin
                b_valid_r <= 1'b0;
            end
        end
    end

    // Read path: sample the register on AR and hold R until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_r  <= R_IDLE;
            ar_ready_r <= 1'b1;
            r_valid_r  <= 1'b0;
            r_id_r     <= {IDLEN{1'b0}};
            r_resp_r   <= RESP_OKAY;
            r_data_r   <= {XLEN{1'b0}};
        end else begin
            r_state_r  <= r_state_nx_s;
            ar_ready_r <= (r_state_nx_s == R_IDLE);
            if (ar_hs_s) begin
                r_valid_r <= 1'b1;
                r_id_r    <= ar_id;
                r_resp_r  <= rd_hit_s ? RESP_OKAY : RESP_SLVERR;
                r_data_r  <= rd_data_s;
            end else if (r_hs_s) begin
                r_valid_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_reg_responder.sv
// Self-checking bench for axi4_reg_responder: vector table, corner sequences,
// and random traffic against an address-map reference model.
module tb_axi4_reg_responder;

    localparam int          NREGS = 8;
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam logic [7:0]  RO    = 8'h20;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  aw_addr;
    logic [4:0]   aw_id;
    logic         aw_valid;
    logic         aw_ready;
    logic [31:0]  w_data;
    logic [3:0]   w_strb;
    logic         w_valid;
    logic         w_ready;
    logic [4:0]   b_id;
    logic [1:0]   b_resp;
    logic         b_valid;
    logic         b_ready;
    logic [31:0]  ar_addr;
    logic [4:0]   ar_id;
    logic         ar_valid;
    logic         ar_ready;
    logic [31:0]  r_data;
    logic [4:0]   r_id;
    logic [1:0]   r_resp;
    logic         r_last;
    logic         r_valid;
    logic         r_ready;
    logic [255:0] ctrl_o;
    logic [255:0] status_i;
    logic [7:0]   wr_pulse_o;

    logic [31:0]  model  [NREGS];
    logic [31:0]  status [NREGS];
    int           checks = 0;
    int           errors = 0;
    logic [1:0]   obs_bresp;
    logic [1:0]   obs_rresp;
    logic [31:0]  obs_rdata;

    for (genvar g = 0; g < NREGS; g++) begin : g_status
        assign status_i[32*g +: 32] = status[g];
    end

    axi4_reg_responder #(.RO_MASK(RO)) dut (
        .clk(clk), .rst(rst),
        .aw_addr(aw_addr), .aw_id(aw_id), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_addr(ar_addr), .ar_id(ar_id), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_id(r_id), .r_resp(r_resp), .r_last(r_last),
        .r_valid(r_valid), .r_ready(r_ready),
        .ctrl_o(ctrl_o), .status_i(status_i), .wr_pulse_o(wr_pulse_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          mode;   // 0: AW+W together, 1: AW leads by 2, 2: W leads by 3
        logic [4:0]  id;
        logic [1:0]  wresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h expected=%08h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=handshake", nm);
    endtask

    // Reference model: window decode by plain arithmetic on the byte offset
    task automatic model_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] resp);
        longint off;
        int k;
        off = longint'(addr) - longint'(BASE);
        if (off >= 0 && off / 4 < NREGS) begin
            k = int'(off / 4);
            d = RO[k] ? status[k] : model[k];
            resp = 2'b00;
        end else begin
            d = 32'h0;
            resp = 2'b10;
        end
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               output logic [1:0] resp, output logic [7:0] pulse);
        longint off;
        int k;
        off = longint'(addr) - longint'(BASE);
        resp = 2'b10;
        pulse = 8'h00;
        if (off >= 0 && off / 4 < NREGS) begin
            k = int'(off / 4);
            if (!RO[k]) begin
`ifdef AXI_REG_WSTRB_EN
                for (int b = 0; b < 4; b++) if (strb[b]) model[k][8*b +: 8] = data[8*b +: 8];
`else
                model[k] = data;
`endif
                resp = 2'b00;
                pulse = 8'(1 << k);
            end
        end
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [4:0] id);
        int n = 0;
        aw_addr = a; aw_id = id; aw_valid = 1'b1;
        while (!aw_ready && n < 50) begin @(negedge clk); n++; end
        if (!aw_ready) timeout("aw_handshake");
        else @(posedge clk);
        #1 aw_valid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        w_data = d; w_strb = s; w_valid = 1'b1;
        while (!w_ready && n < 50) begin @(negedge clk); n++; end
        if (!w_ready) timeout("w_handshake");
        else @(posedge clk);
        #1 w_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [4:0] id);
        int n = 0;
        ar_addr = a; ar_id = id; ar_valid = 1'b1;
        while (!ar_ready && n < 50) begin @(negedge clk); n++; end
        if (!ar_ready) timeout("ar_handshake");
        else @(posedge clk);
        #1 ar_valid = 1'b0;
    endtask

    // B response appears with the new ctrl_o value and the single-cycle pulse
    task automatic wait_b(input logic [4:0] eid, input logic [1:0] eresp, input logic [7:0] epulse, input bit hs);
        int n = 0;
        @(negedge clk);
        while (!b_valid && n < 50) begin @(negedge clk); n++; end
        if (!b_valid) timeout("b_valid");
        else begin
            obs_bresp = b_resp;
            chk("b_id", 32'(b_id), 32'(eid));
            chk("b_resp", 32'(b_resp), 32'(eresp));
            chk("wr_pulse", 32'(wr_pulse_o), 32'(epulse));
            for (int i = 0; i < NREGS; i++) chk($sformatf("ctrl%0d", i), ctrl_o[32*i +: 32], model[i]);
            if (hs) begin
                @(negedge clk);
                chk("b_drop", 32'(b_valid), 32'd0);
                chk("pulse_once", 32'(wr_pulse_o), 32'd0);
            end
        end
    endtask

    task automatic wait_r(input logic [31:0] ed, input logic [1:0] eresp, input logic [4:0] eid);
        int n = 0;
        @(negedge clk);
        while (!r_valid && n < 50) begin @(negedge clk); n++; end
        if (!r_valid) timeout("r_valid");
        else begin
            obs_rdata = r_data;
            obs_rresp = r_resp;
            chk("r_data", r_data, ed);
            chk("r_resp", 32'(r_resp), 32'(eresp));
            chk("r_id", 32'(r_id), 32'(eid));
            chk("r_last", 32'(r_last), 32'd1);
        end
    endtask

    task automatic write_tx(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [4:0] id, input int mode);
        logic [1:0] er;
        logic [7:0] ep;
        model_write(a, d, s, er, ep);
        @(negedge clk);
        fork
            begin
                if (mode == 1) begin
                    repeat (2) @(negedge clk);
                    chk("aw_first_awready", 32'(aw_ready), 32'd0);
                end
                send_w(d, s);
            end
            begin
                if (mode == 2) begin
                    repeat (3) @(negedge clk);
                    chk("w_first_wready", 32'(w_ready), 32'd0);
                end
                send_aw(a, id);
            end
        join
        wait_b(id, er, ep, 1'b1);
    endtask

    task automatic read_tx(input logic [31:0] a, input logic [4:0] id);
        logic [31:0] ed;
        logic [1:0]  er;
        @(negedge clk);
        model_read(a, ed, er);
        send_ar(a, id);
        wait_r(ed, er, id);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, d, ed;
        logic [1:0]  er;
        logic [7:0]  ep;
        int          k;

        vecs[0] = '{32'h0001_0000, 32'h0000_0A2C, 0, 5'h01, 2'b00, 32'h0000_0A2C, 2'b00};
        vecs[1] = '{32'h0001_001C, 32'h0000_0020, 2, 5'h03, 2'b00, 32'h0000_0020, 2'b00};
        vecs[2] = '{32'h0001_0014, 32'h0000_00FF, 0, 5'h04, 2'b10, 32'h0000_0002, 2'b00};
        vecs[3] = '{32'h0001_0020, 32'h0000_1234, 1, 5'h06, 2'b10, 32'h0000_0000, 2'b10};
        vecs[4] = '{32'h0001_0004, 32'hDEAD_BEEF, 1, 5'h1F, 2'b00, 32'hDEAD_BEEF, 2'b00};
        vecs[5] = '{32'h0001_000B, 32'h0000_55AA, 0, 5'h0A, 2'b00, 32'h0000_55AA, 2'b00};
        vecs[6] = '{32'h0000_FFFC, 32'h0000_0077, 0, 5'h02, 2'b10, 32'h0000_0000, 2'b10};
        vecs[7] = '{32'h0001_0018, 32'hCAFE_F00D, 2, 5'h11, 2'b00, 32'hCAFE_F00D, 2'b00};

        for (int i = 0; i < NREGS; i++) begin
            model[i]  = 32'h0;
            status[i] = 32'hA0 + 32'(i);
        end
        status[5] = 32'h0000_0002;

        rst = 1'b1;
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        aw_addr = 32'h0; aw_id = 5'h0; w_data = 32'h0; w_strb = 4'h0;
        ar_addr = 32'h0; ar_id = 5'h0;
        b_ready = 1'b1; r_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_b_valid", 32'(b_valid), 32'd0);
        chk("rst_r_valid", 32'(r_valid), 32'd0);
        chk("rst_pulse", 32'(wr_pulse_o), 32'd0);
        chk("rst_b_id_resp", {25'd0, b_id, b_resp}, 32'd0);
        chk("rst_r_id_resp", {25'd0, r_id, r_resp}, 32'd0);
        chk("rst_r_data", r_data, 32'd0);
        chk("rst_readies", {29'd0, aw_ready, w_ready, ar_ready}, 32'd7);
        for (int i = 0; i < NREGS; i++) chk("rst_ctrl", ctrl_o[32*i +: 32], 32'd0);

        for (int i = 0; i < 8; i++) begin
            write_tx(vecs[i].addr, vecs[i].data, 4'hF, vecs[i].id, vecs[i].mode);
            chk($sformatf("tbl%0d_bresp", i), 32'(obs_bresp), 32'(vecs[i].wresp));
            read_tx(vecs[i].addr, vecs[i].id);
            chk($sformatf("tbl%0d_rdata", i), obs_rdata, vecs[i].rdata);
            chk($sformatf("tbl%0d_rresp", i), 32'(obs_rresp), 32'(vecs[i].rresp));
        end

        // Read sampled on the commit edge must see the pre-write value
        ed = model[2];
        fork
            write_tx(32'h0001_0008, 32'h1111_2222, 4'hF, 5'h08, 0);
            begin
                repeat (2) @(negedge clk);
                send_ar(32'h0001_0008, 5'h09);
                wait_r(ed, 2'b00, 5'h09);
            end
        join
        chk("same_cycle_prewrite", obs_rdata, 32'h0000_55AA);

        // B held under backpressure while a read completes and a second AW waits
        b_ready = 1'b0;
        model_write(32'h0001_000C, 32'h3C3C_3C3C, 4'hF, er, ep);
        @(negedge clk);
        fork
            send_aw(32'h0001_000C, 5'h15);
            send_w(32'h3C3C_3C3C, 4'hF);
        join
        wait_b(5'h15, er, ep, 1'b0);
        read_tx(32'h0001_0000, 5'h07);
        aw_addr = 32'h0001_0010; aw_id = 5'h16; aw_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_b_valid", 32'(b_valid), 32'd1);
            chk("bp_b_id", 32'(b_id), 32'h15);
            chk("bp_b_resp", 32'(b_resp), 32'd0);
            chk("bp_aw_blocked", 32'(aw_ready), 32'd0);
        end
        b_ready = 1'b1;
        model_write(32'h0001_0010, 32'h4444_0000, 4'hF, er, ep);
        fork
            send_aw(32'h0001_0010, 5'h16);
            send_w(32'h4444_0000, 4'hF);
        join
        wait_b(5'h16, er, ep, 1'b1);

        // Byte strobes
        write_tx(32'h0001_0004, 32'h1122_3344, 4'hF, 5'h01, 0);
        write_tx(32'h0001_0004, 32'hAABB_CCDD, 4'b0101, 5'h01, 0);
        read_tx(32'h0001_0004, 5'h01);
`ifdef AXI_REG_WSTRB_EN
        chk("wstrb_merge", obs_rdata, 32'h11BB_33DD);
`else
        chk("wstrb_ignored", obs_rdata, 32'hAABB_CCDD);
`endif
        write_tx(32'h0001_0004, 32'h0000_0000, 4'b0000, 5'h02, 0);
        read_tx(32'h0001_0004, 5'h02);
`ifdef AXI_REG_WSTRB_EN
        chk("wstrb_zero", obs_rdata, 32'h11BB_33DD);
`else
        chk("wstrb_zero", obs_rdata, 32'h0000_0000);
`endif

        // Random traffic against the model
        for (int it = 0; it < 60; it++) begin
            k = int'($urandom_range(0, 11));
            if (k <= 9) a = BASE + 32'(4 * k) + 32'($urandom_range(0, 3));
            else if (k == 10) a = BASE - 32'(4 * $urandom_range(1, 4));
            else a = 32'h0002_0000 + 32'($urandom_range(0, 255));
            status[5] = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                write_tx(a, d, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
                         int'($urandom_range(0, 2)));
            end else begin
                read_tx(a, 5'($urandom_range(0, 31)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_reg_responder.md
Name: axi4_reg_responder

Overview:
AXI4 subordinate (single-beat, burst fields ignored) that terminates a register-mapped window for peripheral configuration and status. It accepts AW/W/AR requests from an AXI initiator and returns B/R responses. It exposes an array of NREGS 32-bit registers: read-write control registers drive `ctrl_o`, and read-only registers sample `status_i`. It is the responder side used behind peripherals such as the UART, and as the target model in peripheral benches.

Parameters:
- ALEN, 32, address width
- XLEN, 32, data width; fixed at 32
- IDLEN, 5, transaction ID width
- NREGS, 8, number of registers (1..16)
- BASE_ADDR, 32'h1_0000, window base; register i sits at BASE_ADDR + 4*i
- RO_MASK, 8'h00, NREGS bits; bit i=1 makes register i read-only (value = status_i slice i)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- aw_addr  in  ALEN  write address
- aw_id  in  IDLEN  write ID
- aw_valid  in  1
- aw_ready  out  1
- w_data  in  XLEN
- w_strb  in  XLEN/8  byte strobes
- w_valid  in  1
- w_ready  out  1
- b_id  out  IDLEN
- b_resp  out  2
- b_valid  out  1
- b_ready  in  1
- ar_addr  in  ALEN
- ar_id  in  IDLEN
- ar_valid  in  1
- ar_ready  out  1
- r_data  out  XLEN
- r_id  out  IDLEN
- r_resp  out  2
- r_last  out  1  constant 1
- r_valid  out  1
- r_ready  in  1
- ctrl_o  out  NREGS*XLEN  register i at bits [32*i+:32]
- status_i  in  NREGS*XLEN  read-only sources, same packing
- wr_pulse_o  out  NREGS  1-cycle strobe, bit i set on the cycle a write commits to RW register i

Behaviour:
- Interface: one clock; reset is synchronous and active-high. The ports are named clk and rst.
- Reset state:
  - Write FSM = W_IDLE, read FSM = R_IDLE.
  - All RW registers = 0; ctrl_o = 0.
  - b_valid = 0, r_valid = 0, wr_pulse_o = 0.
  - b_id, b_resp, r_id, r_resp and r_data = 0.
- Reset mid-transaction: any pending request or response is dropped; no commit occurs.
- Address decode:
  - off = addr - BASE_ADDR; idx = off[ALEN-1:2]; off[1:0] is ignored.
  - A hit requires addr >= BASE_ADDR and idx < NREGS.
  - A miss returns SLVERR (2'b10). An ID miss is not possible.
- Write FSM (ready outputs decoded from state, no combinational path from valid to ready):
  - W_IDLE: aw_ready=1, w_ready=1.
    - Both handshakes in the same cycle: capture both, go to W_COMMIT.
    - AW only: capture addr/id, go to W_DATA.
    - W only: capture data/strb, go to W_ADDR.
  - W_DATA: w_ready=1, aw_ready=0. On the W handshake go to W_COMMIT.
  - W_ADDR: aw_ready=1, w_ready=0. On the AW handshake go to W_COMMIT.
  - W_COMMIT (one cycle, both readies 0):
    - Hit on an RW register: update it, pulse wr_pulse_o[idx], resp OKAY.
    - Hit on an RO register: no update, resp SLVERR.
    - Miss: no update, resp SLVERR.
    - Go to W_RESP.
  - W_RESP: b_valid=1 with captured id and resp held stable. On b_ready go to W_IDLE.
- Write latency: a new register value is visible on ctrl_o in the cycle after W_COMMIT. b_valid rises in that same cycle.
- Read FSM:
  - R_IDLE: ar_ready=1. On the AR handshake, sample the register (RW: stored value; RO: status_i slice) into r_data and go to R_RESP.
  - R_RESP: ar_ready=0, r_valid=1, r_last=1, r_id = captured ID, r_resp OKAY on a hit. A miss returns SLVERR with r_data=0. On r_ready go to R_IDLE.
- Read latency: one cycle from the AR handshake to r_valid.
- Outstanding transactions: at most 1 read and 1 write. The read and write FSMs are independent.
- Same-cycle read and commit to the same register: the read returns the pre-write value.
- Backpressure: b/r payloads must not change while valid=1 and ready=0.

Optional Feature:
- Macro: AXI_REG_WSTRB_EN.
- Defined: a register write updates only the bytes whose w_strb bit is 1. A write with w_strb=0 is OKAY, changes nothing, and still pulses wr_pulse_o.
- Undefined: w_strb is ignored and the full 32-bit word is written.

Test Plan:
1. Write 32'h0000_0A2C to 32'h1_0000 with AW and W in the same cycle, then read 32'h1_0000 -> b_resp=OKAY; ctrl_o[31:0]=32'hA2C one cycle after commit; wr_pulse_o[0] high for exactly 1 cycle; r_data=32'hA2C, r_last=1.
2. W presented 3 cycles before AW (addr 32'h1_001C, data 32'h20, aw_id=5'h3) -> w_ready drops after the W handshake; b_id=5'h3, b_resp=OKAY; ctrl_o[255:224]=32'h20.
3. Read 32'h1_0014 with RO_MASK=8'h20 and status_i slice 5 = 32'h2 -> r_data=32'h2, OKAY. Write 32'hFF to the same address -> SLVERR, slice unchanged, no wr_pulse_o.
4. Write to 32'h1_0020 and read 32'h0_FFFC -> both return SLVERR (2'b10); r_data=0; no register changes.
5. Hold b_ready=0 for 5 cycles after a write, and meanwhile issue a read -> b_valid and b_id stay stable; the read completes independently; no second AW is accepted until the B handshake.
6. With AXI_REG_WSTRB_EN: register 1 = 32'h1122_3344, then write 32'hAABB_CCDD with w_strb=4'b0101 -> register 1 = 32'h11BB_33DD. Without the macro -> 32'hAABB_CCDD.
